shift_sequencer_param: RTL and testbench
========================================

Name: shift_sequencer_param

Overview:
- Parametrised, multi-cycle successor of the 8-bit universal shift register, used as the iterative shifter behind the ARM register-specified shift operand.
- Loads an operand, then shifts it one position per clock for a requested amount. Supported modes: LSL, LSR, ASR, ROR.
- Produces the ARM shifter carry-out, with a start/ready/done handshake.
- The serial fill input is kept so that instances can be cascaded.

Parameters:
- WIDTH, 32, operand width in bits (≥2)
- AMT_W, 8, width of the shift-amount input (ARM uses the bottom byte of Rs)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when ready=1
- mode  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR; latched on accept
- amount  in  AMT_W  number of single-bit steps; latched on accept
- parallel_load  in  WIDTH  operand; latched on accept
- carry_in  in  1  carry_out value used when amount=0
- msb  in  1  serial fill bit for LSL (enters bit 0) and LSR (enters bit WIDTH-1); tie 0 for ARM semantics
- ready  out  1  high in IDLE only
- done  out  1  one-cycle pulse; result valid
- parallel_read  out  WIDTH  internal register, continuously visible (intermediate values during shifting)
- carry_out  out  1  last bit shifted out
- lsb  out  1  parallel_read[0]

Behaviour:
- Only one clock exists. Reset is synchronous and active-high. No asynchronous paths.
- Reset values:
  - state=IDLE, ready=1, done=0
  - parallel_read=0, carry_out=0, lsb=0
  - internal count=0
- States:
  - IDLE: ready=1.
    - start=1 at edge E0 latches parallel_load, mode, amount, and carry_in→carry_out.
    - Next state is SHIFT if amount≠0, otherwise DONE.
  - SHIFT: ready=0. Each edge performs one step and decrements count. The edge at which count goes 1→0 moves the FSM to DONE.
  - DONE: ready=0, done=1 for exactly one cycle. The next edge returns to IDLE; data and carry are held.
- Step definitions (r = register, c = carry):
  - LSL: c←r[W-1]; r←{r[W-2:0],msb}
  - LSR: c←r[0]; r←{msb,r[W-1:1]}
  - ASR: c←r[0]; r←{r[W-1],r[W-1:1]}
  - ROR: c←r[0]; r←{r[0],r[W-1:1]}
- Latency:
  - For amount=k≥1, done is high in the cycle after edge Ek (k+1 edges including the load).
  - For k=0, done is high in the cycle after E0.
  - Next start can be accepted at the edge following the done cycle.
- Large amounts are iterated literally, with no clamping. Results match the ARM register-shift rules:
  - LSL/LSR by WIDTH: result 0, carry = bit shifted last.
  - LSL/LSR by more than WIDTH: result 0, carry 0.
  - ASR saturates to all sign bits; carry = sign.
  - ROR wraps naturally.
- start while ready=0 is ignored, with no queuing.
- mode, amount and parallel_load changes after accept have no effect.
- reset asserted in any state (including mid-SHIFT or DONE) returns all outputs to reset values at that edge. No done pulse is produced for an aborted operation.
- reset and start together: reset wins.

Optional Feature:
- Macro: SHIFT_DOUBLE_STEP_EN.
- Defined:
  - In SHIFT, if count≥2 the FSM performs two steps in one edge (count-=2); otherwise one step.
  - Fill bits for the double step are msb twice (LSL/LSR), the sign bit (ASR), or the rotated bits (ROR).
  - carry_out is the second bit shifted out.
  - Latency for k≥1 is ceil(k/2) shift edges.
- Undefined: single step per edge exactly as above.
- Results and carry must be identical in both builds for all inputs.

Test Plan (WIDTH=8, AMT_W=8, msb=0):
- Reset, then LSL 0x81 amount 1 → done after E1; parallel_read=0x02, carry_out=1, ready=1 one cycle later.
- LSR 0xF0 amount 4 → 0x0F, carry_out=0; ASR 0x80 amount 3 → 0xF0, carry_out=0; intermediate parallel_read sequence checked per edge.
- ROR 0x01 amount 9 → 0x80, carry_out=1, done after E9. amount 0 with carry_in=1 → 0x01 unchanged, carry_out=1, done after E0.
- LSL 0xFF amount 8 → 0x00, carry_out=1; amount 9 → 0x00, carry_out=0. ASR 0x80 amount 200 → 0xFF, carry_out=1.
- start pulsed during SHIFT with new operand → ignored, original result delivered. reset at E2 of LSR 0xAA amount 5 → parallel_read=0, carry_out=0, ready=1, done never pulses.
- With SHIFT_DOUBLE_STEP_EN: LSR 0xF0 amount 5 → 0x07, carry_out=1, done after E3.

Source files
------------

// File: rtl/shift_sequencer_param_if.sv
// shift_sequencer_param_if: request/result bundle for the iterative shifter
interface shift_sequencer_param_if #(parameter int WIDTH = 32, parameter int AMT_W = 8);
  logic start;
  logic [1:0] mode;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] parallel_load;
  logic carry_in;
  logic msb;
  logic ready;
  logic done;
  logic [WIDTH-1:0] parallel_read;
  logic carry_out;
  logic lsb;
  modport master(output start, mode, amount, parallel_load, carry_in, msb,
                 input ready, done, parallel_read, carry_out, lsb);
  modport slave(input start, mode, amount, parallel_load, carry_in, msb,
                output ready, done, parallel_read, carry_out, lsb);
endinterface

// File: rtl/shift_sequencer_param.sv
// shift_sequencer_param: multi-cycle LSL/LSR/ASR/ROR shifter with ARM carry-out
// SHIFT_DOUBLE_STEP_EN: take two steps per edge while at least two remain
module shift_sequencer_param #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
) (
  input logic clock,
  input logic reset,
  shift_sequencer_param_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] r, r_n;
  logic c, c_n;
  logic [AMT_W-1:0] cnt, cnt_n;
  logic [1:0] mode_q, mode_n;
  logic [WIDTH:0] s1;
  function automatic logic [WIDTH:0] step(input logic [1:0] m, input logic [WIDTH-1:0] v, input logic f);
    return m == 2'd0 ? {v[WIDTH-1], v[WIDTH-2:0], f} :
           m == 2'd1 ? {v[0], f, v[WIDTH-1:1]} :
           m == 2'd2 ? {v[0], v[WIDTH-1], v[WIDTH-1:1]} :
                       {v[0], v[0], v[WIDTH-1:1]};
  endfunction
  assign s1 = step(mode_q, r, bus.msb);
`ifdef SHIFT_DOUBLE_STEP_EN
  logic [WIDTH:0] s2;
  logic dbl;
  assign s2 = step(mode_q, s1[WIDTH-1:0], bus.msb);
  assign dbl = cnt >= AMT_W'(2);
`endif
  always_comb begin
    state_n = state;
    r_n = r;
    c_n = c;
    cnt_n = cnt;
    mode_n = mode_q;
    case (state)
      IDLE: if (bus.start) begin
        r_n = bus.parallel_load;
        c_n = bus.carry_in;
        cnt_n = bus.amount;
        mode_n = bus.mode;
        state_n = bus.amount != '0 ? SHIFT : DONE;
      end
      SHIFT: begin
`ifdef SHIFT_DOUBLE_STEP_EN
        {c_n, r_n} = dbl ? s2 : s1;
        cnt_n = cnt - (dbl ? AMT_W'(2) : AMT_W'(1));
`else
        {c_n, r_n} = s1;
        cnt_n = cnt - AMT_W'(1);
`endif
        state_n = cnt_n == '0 ? DONE : SHIFT;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      r <= '0;
      c <= 1'b0;
      cnt <= '0;
      mode_q <= 2'd0;
    end else begin
      state <= state_n;
      r <= r_n;
      c <= c_n;
      cnt <= cnt_n;
      mode_q <= mode_n;
    end
  end
  assign bus.ready = state == IDLE;
  assign bus.done = state == DONE;
  assign bus.parallel_read = r;
  assign bus.carry_out = c;
  assign bus.lsb = r[0];
endmodule

// File: tb/tb_shift_sequencer_param.sv
// tb_shift_sequencer_param: directed checks of the 8-bit shift sequencer
module tb_shift_sequencer_param;
`ifdef SHIFT_DOUBLE_STEP_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  int edges;
  logic seen;
  shift_sequencer_param_if #(.WIDTH(8), .AMT_W(8)) bus();
  shift_sequencer_param #(.WIDTH(8), .AMT_W(8)) dut (.clock(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int lat(input int k);
    return DBL ? (k + 1) / 2 : k;
  endfunction

  task automatic launch(input logic [1:0] m, input logic [7:0] a, input logic [7:0] v, input logic ci);
    @(negedge clk);
    bus.mode = m;
    bus.amount = a;
    bus.parallel_load = v;
    bus.carry_in = ci;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    edges = 0;
  endtask

  task automatic finish(input string tag, input logic [7:0] er, input logic ec, input int ee);
    while (!bus.done && edges < 300) begin
      @(posedge clk);
      #1 edges++;
    end
    chk({tag, "_edges"}, edges, ee);
    chk({tag, "_r"}, {24'd0, bus.parallel_read}, {24'd0, er});
    chk({tag, "_c"}, {31'd0, bus.carry_out}, {31'd0, ec});
    @(posedge clk);
    #1 chk({tag, "_idle"}, {30'd0, bus.ready, bus.done}, 32'd2);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.mode = 2'd0;
    bus.amount = 8'd0;
    bus.parallel_load = 8'd0;
    bus.carry_in = 1'b0;
    bus.msb = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("rst_state", {21'd0, bus.ready, bus.done, bus.carry_out, bus.lsb, bus.parallel_read},
           {21'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    rst = 1'b0;
    launch(2'd0, 8'd1, 8'h81, 1'b0);
    finish("lsl81_1", 8'h02, 1'b1, lat(1));
    launch(2'd1, 8'd4, 8'hF0, 1'b0);
    for (int i = 1; i <= lat(4); i++) begin
      @(posedge clk);
      #1 edges++;
      chk($sformatf("lsr_mid%0d", i), {24'd0, bus.parallel_read},
          {24'd0, 8'hF0 >> (DBL ? ((2 * i > 4) ? 4 : 2 * i) : i)});
    end
    finish("lsrF0_4", 8'h0F, 1'b0, lat(4));
    launch(2'd2, 8'd3, 8'h80, 1'b0);
    finish("asr80_3", 8'hF0, 1'b0, lat(3));
    launch(2'd3, 8'd9, 8'h01, 1'b0);
    finish("ror01_9", 8'h80, 1'b1, lat(9));
    launch(2'd1, 8'd0, 8'h01, 1'b1);
    finish("amt0", 8'h01, 1'b1, 0);
    launch(2'd0, 8'd8, 8'hFF, 1'b0);
    finish("lslFF_8", 8'h00, 1'b1, lat(8));
    launch(2'd0, 8'd9, 8'hFF, 1'b1);
    finish("lslFF_9", 8'h00, 1'b0, lat(9));
    launch(2'd2, 8'd200, 8'h80, 1'b0);
    finish("asr80_200", 8'hFF, 1'b1, lat(200));
    launch(2'd1, 8'd5, 8'hF0, 1'b0);
    finish("lsrF0_5", 8'h07, 1'b1, lat(5));
    launch(2'd1, 8'd4, 8'hF0, 1'b0);
    bus.mode = 2'd0;
    bus.amount = 8'd1;
    bus.parallel_load = 8'h55;
    bus.carry_in = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1 edges++;
    bus.start = 1'b0;
    finish("ignore_start", 8'h0F, 1'b0, lat(4));
    launch(2'd1, 8'd5, 8'hAA, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 chk("abort_state", {21'd0, bus.ready, bus.done, bus.carry_out, bus.lsb, bus.parallel_read},
           {21'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1 seen = seen | bus.done;
    end
    chk("abort_nodone", {31'd0, seen}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
